pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt control for the five-stage pipeline registers
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dcache_stall,
    input  logic        icache_stall,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        hlt_wb,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_clr,
    output logic        idex_we,
    output logic        idex_clr,
    output logic        exmem_we,
    output logic        exmem_clr,
    output logic        memwb_we,
    output logic        memwb_clr,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [7:0]  dmiss_events
);
    typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2, HALT = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_q, stall_d;
    logic [7:0]  dmiss_q, dmiss_d;
    logic        stall_cyc;

    // Prioritised control decode (halt > D-miss > I-miss > load-use > branch), next state and counter updates
    always_comb begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        ifid_clr  = 1'b0;
        idex_we   = 1'b0;
        idex_clr  = 1'b0;
        exmem_we  = 1'b0;
        exmem_clr = 1'b0;
        memwb_we  = 1'b0;
        memwb_clr = 1'b0;
        stall_cyc = 1'b0;
        state_d   = state_q;
        if (!rst_n) begin
            state_d = RUN;
        end else if (state_q == HALT || hlt_wb) begin
            state_d = HALT;
        end else begin
            state_d = dcache_stall ? DMISS : (icache_stall ? IMISS : RUN);
            if (dcache_stall) begin
                stall_cyc = 1'b1;
            end else if (icache_stall) begin
                ifid_we   = 1'b1;
                ifid_clr  = 1'b1;
                idex_we   = 1'b1;
                exmem_we  = 1'b1;
                memwb_we  = 1'b1;
                stall_cyc = 1'b1;
            end else if (load_use) begin
                idex_we   = 1'b1;
                idex_clr  = 1'b1;
                exmem_we  = 1'b1;
                memwb_we  = 1'b1;
                stall_cyc = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                ifid_clr = branch_taken;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
        end
        halted_d = halted_q | (state_d == HALT);
        stall_d  = (stall_cyc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        dmiss_d  = (state_d == DMISS && state_q != DMISS && dmiss_q != 8'hFF) ? dmiss_q + 8'd1 : dmiss_q;
    end

    // State, sticky halt flag and saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            stall_q  <= 16'd0;
            dmiss_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
            dmiss_q  <= dmiss_d;
        end
    end

    assign state        = state_q;
    assign halted       = halted_q;
    assign stall_cycles = stall_q;
    assign dmiss_events = dmiss_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus with a per-cycle reference model of the hazard controller
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dcache_stall = 1'b0, icache_stall = 1'b0, load_use = 1'b0, branch_taken = 1'b0, hlt_wb = 1'b0;
    logic        pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, exmem_clr, memwb_we, memwb_clr;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [7:0]  dmiss_events;

    int n_chk = 0;
    int n_fail = 0;

    // control vector order: pc_we ifid_we ifid_clr idex_we idex_clr exmem_we exmem_clr memwb_we memwb_clr
    localparam logic [8:0] C_NORM = 9'b1_10_10_10_10;
    localparam logic [8:0] C_BR   = 9'b1_11_10_10_10;
    localparam logic [8:0] C_IMIS = 9'b0_11_10_10_10;
    localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
    localparam logic [8:0] C_ZERO = 9'b0_00_00_00_00;

    logic [8:0] ctrl;
    assign ctrl = {pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, exmem_clr, memwb_we, memwb_clr};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .dcache_stall(dcache_stall), .icache_stall(icache_stall), .load_use(load_use),
        .branch_taken(branch_taken), .hlt_wb(hlt_wb),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_clr(ifid_clr), .idex_we(idex_we), .idex_clr(idex_clr),
        .exmem_we(exmem_we), .exmem_clr(exmem_clr), .memwb_we(memwb_we), .memwb_clr(memwb_clr),
        .halted(halted), .state(state), .stall_cycles(stall_cycles), .dmiss_events(dmiss_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: abstract state as integers, counters as saturating integers
    int m_st = 0, m_halt = 0, m_stall = 0, m_dm = 0;
    int p_st = 0, p_halt = 0, p_stall = 0, p_dm = 0;

    function automatic logic [8:0] exp_ctrl(input int st);
        if (!rst_n || st == 3 || hlt_wb || dcache_stall) return C_ZERO;
        if (icache_stall) return C_IMIS;
        if (load_use) return C_LU;
        if (branch_taken) return C_BR;
        return C_NORM;
    endfunction

    // compare every cycle on the falling edge, then stage the model's next state
    always @(negedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_halt = 0; m_stall = 0; m_dm = 0;
        end
        chk("ctrl", int'(ctrl), int'(exp_ctrl(m_st)));
        chk("state", int'(state), m_st);
        chk("halted", int'(halted), m_halt);
        chk("stall_cycles", int'(stall_cycles), m_stall);
        chk("dmiss_events", int'(dmiss_events), m_dm);
        if (!rst_n) begin
            p_st = 0; p_halt = 0; p_stall = 0; p_dm = 0;
        end else begin
            bit halting;
            halting = (m_st == 3) || hlt_wb;
            p_st = halting ? 3 : dcache_stall ? 2 : icache_stall ? 1 : 0;
            p_halt = (p_st == 3) ? 1 : m_halt;
            p_stall = (!halting && (dcache_stall || icache_stall || load_use)) ? ((m_stall < 65535) ? m_stall + 1 : 65535) : m_stall;
            p_dm = (p_st == 2 && m_st != 2) ? ((m_dm < 255) ? m_dm + 1 : 255) : m_dm;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_st = p_st; m_halt = p_halt; m_stall = p_stall; m_dm = p_dm;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic d, input logic i, input logic lu, input logic br, input logic h);
        dcache_stall = d; icache_stall = i; load_use = lu; branch_taken = br; hlt_wb = h;
    endtask

    initial begin
        int base;
        // reset held
        @(negedge clk);
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_state", int'(state), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("norm_ctrl", int'(ctrl), 9'h1AA);
        chk("norm_cnt", int'(stall_cycles) + int'(dmiss_events), 0);
        tick();
        // D-miss 3 cycles
        set_in(1, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("dmiss_ctrl", int'(ctrl), 0);
            tick();
        end
        chk("dmiss_state", int'(state), 2);
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_dmiss_ctrl", int'(ctrl), 9'h1AA);
        chk("dmiss_events", int'(dmiss_events), 1);
        chk("dmiss_stall", int'(stall_cycles), 3);
        tick();
        chk("after_dmiss_state", int'(state), 0);
        // D and I miss together, then I only
        set_in(1, 1, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("di_ctrl", int'(ctrl), 0);
            tick();
        end
        chk("di_state", int'(state), 2);
        chk("di_stall", int'(stall_cycles), 5);
        set_in(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("imiss_ctrl", int'(ctrl), 9'h0EA);
        tick();
        chk("imiss_state", int'(state), 1);
        // load-use with branch: load-use wins
        set_in(0, 0, 1, 1, 0);
        base = int'(stall_cycles);
        @(negedge clk);
        chk("lu_br_ctrl", int'(ctrl), 9'h03A);
        tick();
        chk("lu_br_stall_delta", int'(stall_cycles) - base, 1);
        set_in(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("br_ctrl", int'(ctrl), 9'h1EA);
        tick();
        // halt together with D-miss
        set_in(1, 0, 0, 0, 1);
        base = int'(stall_cycles);
        @(negedge clk);
        chk("hlt_ctrl", int'(ctrl), 0);
        tick();
        chk("hlt_state", int'(state), 3);
        chk("hlt_halted", int'(halted), 1);
        set_in(1, 1, 1, 1, 0);
        repeat (3) tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("halt_absorb_ctrl", int'(ctrl), 0);
        chk("halt_frozen_stall", int'(stall_cycles), base);
        chk("halt_frozen_dmiss", int'(dmiss_events), 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_halted", int'(halted), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ctrl", int'(ctrl), 9'h1AA);
        tick();
        // dmiss_events saturation
        repeat (260) begin
            set_in(1, 0, 0, 0, 0);
            tick();
            set_in(0, 0, 0, 0, 0);
            tick();
        end
        chk("dmiss_sat", int'(dmiss_events), 255);
        // stall_cycles saturation
        set_in(0, 0, 1, 0, 0);
        repeat (65540) tick();
        chk("stall_sat", int'(stall_cycles), 16'hFFFF);
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
